// File: rtl/huffman_pkg.sv
// Shared types and constants for the 6-symbol Huffman coder stages.
package huffman_pkg;

  localparam int NUM_SYM = 6;
  localparam int CW      = 8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [3:0] len;
    logic [7:0] bits;
  } code_t;

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, m[i]};
    return n;
  endfunction

endpackage

// File: rtl/huffman_bitbuf.sv
// 16-bit left-aligned bit accumulator: codes append below the valid bits,
// whole bytes leave from the top.
module huffman_bitbuf
  import huffman_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_append,
  input  logic [CW-1:0] i_code,
  input  logic [3:0]    i_len,
  input  logic          i_drain,
  input  logic          i_flush,
  output logic [7:0]    o_hi,
  output logic [3:0]    o_bc
);

  logic [15:0] r_buf;
  logic [3:0]  r_bc;
  logic [4:0]  w_shift;

  // bc + len never exceeds 15, so the shift is always at least 1.
  assign w_shift = 5'd16 - {1'b0, r_bc} - {1'b0, i_len};

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf <= '0;
      r_bc  <= '0;
    end else if (i_flush) begin
      r_buf <= '0;
      r_bc  <= '0;
    end else if (i_drain) begin
      r_buf <= {r_buf[7:0], 8'h00};
      r_bc  <= r_bc - 4'd8;
    end else if (i_append) begin
      r_buf <= r_buf | ({8'h00, i_code} << w_shift);
      r_bc  <= r_bc + i_len;
    end
  end

  assign o_hi = r_buf[15:8];
  assign o_bc = r_bc;

endmodule

// File: rtl/huffman_packer.sv
// Latches the Huffman code table, maps symbols to codes and packs them
// MSB-first into bytes on a valid/ready port, zero-padding the final byte.
module huffman_packer #(
  parameter int NUM_SYM = 6,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          code_valid,
  input  logic [CW-1:0] HC1, HC2, HC3, HC4, HC5, HC6,
  input  logic [CW-1:0] M1, M2, M3, M4, M5, M6,
  input  logic          sym_valid,
  input  logic [7:0]    sym_data,
  input  logic          sym_last,
  output logic          sym_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [15:0]   nbytes,
  output logic          err
);
  import huffman_pkg::*;

  state_t        r_state;
  code_t         r_table [NUM_SYM];
  logic          r_out_valid, r_out_last, r_err, r_zero_pend;
  logic [7:0]    r_out_data;
  logic [15:0]   r_nbytes;

  logic [CW-1:0] w_hc [NUM_SYM];
  logic [CW-1:0] w_m  [NUM_SYM];
  logic [7:0]    w_hi;
  logic [3:0]    w_bc;
  logic [2:0]    w_idx;
  code_t         w_entry;
  logic          w_out_free, w_accept, w_legal, w_append, w_drain, w_flush, w_zero;

  assign w_hc[0] = HC1; assign w_hc[1] = HC2; assign w_hc[2] = HC3;
  assign w_hc[3] = HC4; assign w_hc[4] = HC5; assign w_hc[5] = HC6;
  assign w_m[0]  = M1;  assign w_m[1]  = M2;  assign w_m[2]  = M3;
  assign w_m[3]  = M4;  assign w_m[4]  = M5;  assign w_m[5]  = M6;

  assign w_legal    = (sym_data != 8'd0) && (sym_data <= 8'(NUM_SYM));
  assign w_idx      = sym_data[2:0] - 3'd1;
  assign w_out_free = !r_out_valid || out_ready;
  assign sym_ready  = (r_state == RUN) && (w_bc < 4'd8);
  assign w_accept   = sym_valid && sym_ready;
  assign w_append   = w_accept && w_legal;
  assign w_drain    = (w_bc >= 4'd8) && w_out_free;
  assign w_flush    = (r_state == FLUSH) && (w_bc != 4'd0) && (w_bc < 4'd8) && w_out_free;
  assign w_zero     = (r_state == FLUSH) && r_zero_pend && w_out_free;

  // NOTE: every combinational output gets a default before any branch so no
  // latch is inferred when the symbol is illegal.
  always_comb begin
    w_entry = '0;
    if (w_legal) w_entry = r_table[w_idx];
  end

  huffman_bitbuf u_bitbuf (
    .clk      (clk),
    .reset    (reset),
    .i_append (w_append),
    .i_code   (w_entry.bits),
    .i_len    (w_entry.len),
    .i_drain  (w_drain),
    .i_flush  (w_flush),
    .o_hi     (w_hi),
    .o_bc     (w_bc)
  );

  // NOTE: the code table is a handful of flops that must read as cleared
  // after reset, so unlike a RAM it is included in the async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      for (int i = 0; i < NUM_SYM; i++) r_table[i] <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_nbytes    <= '0;
      r_err       <= 1'b0;
      r_zero_pend <= 1'b0;
    end else begin
      if (r_out_valid && out_ready && r_nbytes != 16'hFFFF)
        r_nbytes <= r_nbytes + 16'd1;

      if (w_out_free) begin
        if (w_drain) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_hi;
          r_out_last  <= (r_state == FLUSH) && (w_bc == 4'd8);
        end else if (w_flush) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_hi;
          r_out_last  <= 1'b1;
        end else if (w_zero) begin
          r_out_valid <= 1'b1;
          r_out_data  <= 8'h00;
          r_out_last  <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end

      if (w_accept && !w_legal) r_err <= 1'b1;

      case (r_state)
        IDLE: if (code_valid) begin
          for (int i = 0; i < NUM_SYM; i++) begin
            r_table[i].len  <= popcount8(w_m[i]);
            r_table[i].bits <= w_hc[i] & w_m[i];
          end
          r_nbytes <= '0;
          r_err    <= 1'b0;
          r_state  <= RUN;
        end
        RUN: if (w_accept && sym_last) begin
          // An illegal final symbol on an empty buffer still owes one byte.
          r_zero_pend <= !w_legal && (w_bc == 4'd0);
          r_state     <= FLUSH;
        end
        FLUSH: begin
          if (w_zero) r_zero_pend <= 1'b0;
          if (r_out_valid && r_out_last && out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign nbytes    = r_nbytes;
  assign err       = r_err;

endmodule

// File: tb/tb_huffman_packer.sv
// Bench for huffman_packer: bit-queue reference model, per-cycle output
// compare, and directed streams with literal expected bytes.
module tb_huffman_packer;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } byte_t;

  logic        clk = 1'b0, reset = 1'b1, code_valid = 1'b0;
  logic [7:0]  HC1 = '0, HC2 = '0, HC3 = '0, HC4 = '0, HC5 = '0, HC6 = '0;
  logic [7:0]  M1 = '0, M2 = '0, M3 = '0, M4 = '0, M5 = '0, M6 = '0;
  logic        sym_valid = 1'b0, sym_last = 1'b0, out_ready = 1'b1;
  logic [7:0]  sym_data = '0;
  logic        sym_ready, out_valid, out_last, err;
  logic [7:0]  out_data;
  logic [15:0] nbytes;

  int n_tests = 0, n_fail = 0;

  logic [7:0] t_hc [1:6] = '{8'h01, 8'h01, 8'h00, 8'h03, 8'h05, 8'h04};
  logic [7:0] t_m  [1:6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};

  bit    m_bits [$];
  byte_t exp_q  [$];
  byte_t act_log[$];
  logic  exp_err = 1'b0;

  huffman_packer #(.NUM_SYM(6), .CW(8)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last),
    .sym_ready(sym_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .nbytes(nbytes), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic byte_t logged(input int i);
    byte_t b;
    b.data = 8'hEE;
    b.last = 1'b0;
    if (i < act_log.size()) b = act_log[i];
    return b;
  endfunction

  task automatic model_emit(input logic last);
    byte_t e;
    for (int k = 0; k < 8; k++) e.data[7-k] = m_bits.pop_front();
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Reference: a flat bit stream cut into bytes; the final byte is padded.
  task automatic model_push(input int sym, input logic last);
    if (sym >= 1 && sym <= 6) begin
      for (int b = $countones(t_m[sym]) - 1; b >= 0; b--) m_bits.push_back(t_hc[sym][b]);
    end else begin
      exp_err = 1'b1;
    end
    if (!last) begin
      while (m_bits.size() >= 8) model_emit(1'b0);
    end else begin
      if (m_bits.size() == 0) repeat (8) m_bits.push_back(1'b0);
      while (m_bits.size() % 8 != 0) m_bits.push_back(1'b0);
      while (m_bits.size() > 0) model_emit(m_bits.size() == 8);
    end
  endtask

  task automatic load_codes();
    @(negedge clk);
    HC1 = t_hc[1]; HC2 = t_hc[2]; HC3 = t_hc[3]; HC4 = t_hc[4]; HC5 = t_hc[5]; HC6 = t_hc[6];
    M1 = t_m[1]; M2 = t_m[2]; M3 = t_m[3]; M4 = t_m[4]; M5 = t_m[5]; M6 = t_m[6];
    code_valid = 1'b1;
    m_bits.delete();
    exp_q.delete();
    act_log.delete();
    exp_err = 1'b0;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic send_sym(input int sym, input logic last);
    bit ok = 0;
    sym_valid = 1'b1;
    sym_data  = 8'(sym);
    sym_last  = last;
    for (int c = 0; c < 50; c++) begin
      if (sym_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) model_push(sym, last);
    else check("sym_accept_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  // Compare process: every handshake against the model, plus hold stability.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  always @(negedge clk) begin
    byte_t e;
    #2;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        e.data = out_data;
        e.last = out_last;
        act_log.push_back(e);
        if (exp_q.size() == 0) begin
          check("unexpected_byte_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("byte_data", 32'(out_data), 32'(e.data));
          check("byte_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_t b;
    #1;
    check("rst_sym_ready", 32'(sym_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_nbytes",    32'(nbytes),    32'd0);
    check("rst_err",       32'(err),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_sym_ready", 32'(sym_ready), 32'd0);

    // Eight 1-bit codes fill exactly one byte.
    load_codes();
    for (int i = 0; i < 8; i++) send_sym(1, i == 7);
    wait_done();
    b = logged(0);
    check("t1_count", 32'(act_log.size()), 32'd1);
    check("t1_b0", {23'd0, b.last, b.data}, 32'h1FF);
    check("t1_nbytes", 32'(nbytes), 32'd1);
    check("t1_err", 32'(err), 32'(exp_err));

    // "01" x4.
    load_codes();
    for (int i = 0; i < 4; i++) send_sym(2, i == 3);
    wait_done();
    b = logged(0);
    check("t2_b0", {23'd0, b.last, b.data}, 32'h155);
    check("t2_nbytes", 32'(nbytes), 32'd1);

    // 10 bits: full byte then padded remainder.
    load_codes();
    send_sym(6, 1'b0);
    send_sym(6, 1'b1);
    wait_done();
    b = logged(0);
    check("t3_b0", {23'd0, b.last, b.data}, 32'h021);
    b = logged(1);
    check("t3_b1", {23'd0, b.last, b.data}, 32'h100);
    check("t3_nbytes", 32'(nbytes), 32'd2);

    // Backpressure: first byte must hold while out_ready is low.
    load_codes();
    out_ready = 1'b0;
    send_sym(3, 1'b0);
    send_sym(4, 1'b0);
    send_sym(5, 1'b1);
    repeat (4) @(negedge clk);
    check("t4_held_valid", 32'(out_valid), 32'd1);
    check("t4_held_data",  32'(out_data),  32'h06);
    check("t4_held_last",  32'(out_last),  32'd0);
    check("t4_sym_ready",  32'(sym_ready), 32'd0);
    out_ready = 1'b1;
    wait_done();
    b = logged(0);
    check("t4_b0", {23'd0, b.last, b.data}, 32'h006);
    b = logged(1);
    check("t4_b1", {23'd0, b.last, b.data}, 32'h150);
    check("t4_nbytes", 32'(nbytes), 32'd2);

    // Illegal symbol contributes no bits but sets err.
    load_codes();
    send_sym(7, 1'b0);
    send_sym(1, 1'b1);
    wait_done();
    b = logged(0);
    check("t5_b0", {23'd0, b.last, b.data}, 32'h180);
    check("t5_err", 32'(err), 32'(exp_err));
    check("t5_err_lit", 32'(err), 32'd1);

    // Illegal final symbol on an empty buffer yields a lone 0x00.
    load_codes();
    send_sym(2, 1'b0);
    send_sym(2, 1'b0);
    send_sym(2, 1'b0);
    send_sym(2, 1'b0);
    send_sym(0, 1'b1);
    wait_done();
    b = logged(1);
    check("t5b_b1", {23'd0, b.last, b.data}, 32'h100);
    check("t5b_nbytes", 32'(nbytes), 32'd2);

    // Reset mid-stream.
    load_codes();
    send_sym(4, 1'b0);
    send_sym(4, 1'b0);
    send_sym(4, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_nbytes",    32'(nbytes),    32'd0);
    check("mid_rst_sym_ready", 32'(sym_ready), 32'd0);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    exp_q.delete();
    m_bits.delete();
    @(negedge clk);
    reset = 1'b0;
    sym_valid = 1'b1;
    sym_data  = 8'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_refuse", 32'(sym_ready), 32'd0);
    end
    sym_valid = 1'b0;
    check("post_rst_no_out", 32'(out_valid), 32'd0);
    load_codes();
    send_sym(2, 1'b1);
    wait_done();
    b = logged(0);
    check("t6_b0", {23'd0, b.last, b.data}, 32'h140);
    check("t6_nbytes", 32'(nbytes), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/huffman_packer.md
# huffman_packer

Downstream stage of the 6-symbol Huffman coder. Latches the code table (HC1..HC6, M1..M6) when `code_valid` pulses, then accepts a stream of gray symbols (values 1..6), looks up each symbol's variable-length code and packs the codes MSB-first into bytes. Bytes leave on a valid/ready output port, and the final partial byte is zero-padded and flagged `out_last`.

## Interface
Parameters
- `NUM_SYM`, 6: number of symbols and code table entries.
- `CW`, 8: code and mask width.

Ports
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `code_valid`  in  1  one-cycle pulse; code table inputs are valid in this cycle.
- `HC1..HC6`  in  8 each  code bits, leaf-level bit in bit0.
- `M1..M6`  in  8 each  contiguous low-aligned mask; code length L = popcount(M), 1..8.
- `sym_valid`  in  1  symbol offered.
- `sym_data`  in  8  symbol value; legal range 1..6.
- `sym_last`  in  1  qualifies the final symbol of the stream.
- `sym_ready`  out  1  symbol accepted when `sym_valid && sym_ready`.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  8  packed byte; first code bit is in bit7.
- `out_last`  out  1  the byte on `out_data` is the final byte of the stream.
- `out_ready`  in  1  downstream accepts the byte.
- `nbytes`  out  16  count of bytes handed off on the output port in the current stream.
- `err`  out  1  sticky flag; set when an illegal symbol is received.

## Operation
- States:
  - IDLE: wait for codes. `code_valid` latches the table → RUN; also clears `nbytes` and `err`.
  - RUN: accepting symbols. An accepted `sym_last` → FLUSH.
  - FLUSH: drain the buffer; the final handshake on the output port → IDLE.
- `code_valid` outside IDLE is ignored; the table stays unchanged.
- Code emission order: HC bits [L-1] down to [0]. Bit L-1 is the root-side bit and is emitted first.
- Bit buffer:
  - 16-bit, valid bits left-aligned, with count `bc` (0..15).
  - Append: `buf |= code << (16-bc-L)`, `bc += L`.
- `sym_ready = (state==RUN) && (bc < 8)`. With bc ≤ 7 and L ≤ 8, `bc` never exceeds 15.
- Drain condition: `bc ≥ 8` and the output register is free (`!out_valid || out_ready`).
  - Action: `out_data <= buf[15:8]`, `buf <<= 8`, `bc -= 8`.
  - Append and drain never occur in the same cycle, because they require disjoint `bc` ranges.
- FLUSH:
  - Drain full bytes first.
  - When 0 < `bc` < 8: emit `buf[15:8]`, whose low bits are already zero, and set `bc=0`.
  - Set `out_last` on the byte that leaves `bc==0` in FLUSH.
  - Every stream yields at least one byte, since L ≥ 1.
- Illegal symbol (0 or >6): it is accepted, no bits are appended, and `err` is set.
  - If the illegal symbol carries `sym_last` and `bc==0`, emit a single 0x00 byte with `out_last`.
- `nbytes` increments on each output handshake and saturates at 0xFFFF.

## Timing
- Reset values:
  - All outputs are 0.
  - State IDLE, `buf`=0, `bc`=0, table cleared.
- Latency: a symbol accepted in cycle N is in the buffer at N+1. If `bc ≥ 8` and the output register is free, `out_valid` is high at N+2.
- `out_data` and `out_last` are held stable while `out_valid && !out_ready`.
- Throughput: at most one byte per cycle, and at most one symbol per cycle while `bc < 8`.
- `sym_ready` is combinational from registered state only. It does not depend on `sym_valid`.
- Reset mid-stream returns to IDLE immediately. A partially packed byte is discarded, and the next stream needs a new `code_valid`.

## Structure
- `huffman_pkg` holds:
  - `NUM_SYM` and `CW` constants.
  - state enum {IDLE, RUN, FLUSH}.
  - packed struct `code_t {logic [3:0] len; logic [7:0] bits;}`.
- Table latch: length is computed once per entry at `code_valid` as popcount(M), so lookup is a pure index into `code_t [6]`.
- Sub-module `huffman_bitbuf`: the 16-bit left-aligned accumulator, with append, drain and flush ports, plus `bc`.

## Test plan
Common code table: HC1=01/M1=01 ("1"), HC2=01/M2=03 ("01"), HC3=00/M3=07 ("000"), HC4=03/M4=0F ("0011"), HC5=05/M5=1F ("00101"), HC6=04/M6=1F ("00100").
- Symbol 1 ×8, `sym_last` on the 8th, `out_ready`=1 → one byte 0xFF with `out_last`=1, `nbytes`=1.
- Symbols 2,2,2,2 with `sym_last` on the last → 0x55 with `out_last`, `nbytes`=1.
- Symbols 6,6 with `sym_last` on the last → 0x21 (`out_last`=0), then 0x00 (`out_last`=1), `nbytes`=2.
- Symbols 3,4,5 (12 bits) with `out_ready` held low → 0x06 is held stable and `sym_ready` stays low while the buffer holds the second byte's bits. Release `out_ready` → 0x06, then 0x50 with `out_last`.
- Symbol 7 then symbol 1 with `sym_last` → `err`=1; the 7 contributes no bits; output 0x80 with `out_last`.
- Assert `reset` after 3 symbols of a stream → all outputs 0 and IDLE. Symbols are then refused (`sym_ready`=0) until the next `code_valid`.
